// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
// State encoding and an ID-width helper that never returns zero.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; master drives requests and the full flag.
// slave is the arbiter's view.
interface fifo_wr_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 512,
  parameter int ID_W    = 2
);
  logic [N_PORTS-1:0]       s_valid;
  logic [N_PORTS-1:0]       s_last;
  logic [N_PORTS*WIDTH-1:0] s_data;
  logic [N_PORTS-1:0]       s_ready;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data;
  logic                     fifo_full;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
  logic                     err_timeout;
  logic [ID_W-1:0]          err_port;

  modport master (
    output s_valid, s_last, s_data, fifo_full,
    input  s_ready, fifo_wr_en, fifo_data, grant_id, busy, err_timeout, err_port
  );

  modport slave (
    input  s_valid, s_last, s_data, fifo_full,
    output s_ready, fifo_wr_en, fifo_data, grant_id, busy, err_timeout, err_port
  );
endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo N_PORTS.
// Zero latency; returns a one-hot grant (all zero when nothing requests) and its index.
module rr_priority_pick #(
  parameter int N_PORTS = 4,
  parameter int ID_W    = 2
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [N_PORTS-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);

  always_comb begin
    int              j;
    logic            found;
    logic [ID_W-1:0] w_j;
    j     = 0;
    found = 1'b0;
    w_j   = '0;
    o_gnt = '0;
    o_idx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      // explicit wrap so non-power-of-2 port counts never alias
      j = int'(i_ptr) + k;
      if (j >= N_PORTS) j = j - N_PORTS;
      w_j = ID_W'(j);
      if (!found && i_req[w_j]) begin
        found      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter for the async_fifo write port; 1 arbitration cycle per frame, then 1 beat/cycle.
// fifo_full drops s_ready combinationally and holds the grant; a silent granted port is released by the watchdog.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 512,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int ID_W = clog2_min1(N_PORTS);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_err_port;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_wd;

  logic [N_PORTS-1:0] w_pick_gnt;
  logic [ID_W-1:0]    w_pick_idx;
  logic               w_pick_any;
  logic               w_busy;
  logic               w_vld_g;
  logic               w_last_g;
  logic               w_ready_g;
  logic               w_xfer;
  logic [CNT_W-1:0]   w_wd_inc;
  logic               w_wd_hit;
  logic [ID_W-1:0]    w_next_ptr;
  logic [WIDTH-1:0]   w_port_dat [N_PORTS];

  rr_priority_pick #(
    .N_PORTS (N_PORTS),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req (bus.s_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port_dat
    assign w_port_dat[i] = bus.s_data[i*WIDTH +: WIDTH];
  end

  assign w_pick_any = |w_pick_gnt;
  assign w_busy     = (r_state == ST_BURST);
  assign w_vld_g    = bus.s_valid[r_grant_id];
  assign w_last_g   = bus.s_last[r_grant_id];
  // rst gates the handshake so nothing is written while reset is held
  assign w_ready_g  = w_busy && !bus.fifo_full && !rst;
  assign w_xfer     = w_ready_g && w_vld_g;
  assign w_wd_inc   = r_wd + CNT_W'(1);
  assign w_wd_hit   = (TIMEOUT != 0) && (w_wd_inc == CNT_W'(TIMEOUT));
  assign w_next_ptr = (r_grant_id == ID_W'(N_PORTS - 1)) ? '0 : r_grant_id + ID_W'(1);

  always_comb begin
    bus.s_ready = '0;
    if (w_ready_g) bus.s_ready[r_grant_id] = 1'b1;
  end

  assign bus.fifo_wr_en  = w_xfer;
  assign bus.fifo_data   = w_port_dat[r_grant_id];
  assign bus.grant_id    = r_grant_id;
  assign bus.busy        = w_busy;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_port    = r_err_port;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_err_port    <= '0;
      r_err_timeout <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state    <= ST_BURST;
            r_grant_id <= w_pick_idx;
            r_wd       <= '0;
          end
        end
        ST_BURST: begin
          if (w_xfer) begin
            r_wd <= '0;
            if (w_last_g) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end else if (!w_vld_g && (TIMEOUT != 0)) begin
            // only a silent port ages; a full FIFO with valid held never does
            if (w_wd_hit) begin
              r_state       <= ST_IDLE;
              r_rr_ptr      <= w_next_ptr;
              r_err_port    <= r_grant_id;
              r_err_timeout <= 1'b1;
              r_wd          <= '0;
            end else begin
              r_wd <= w_wd_inc;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + randomized bench for fifo_wr_arbiter: 4-port DUT against a cycle reference model,
// plus a 3-port DUT for pointer wrap.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NA   = 4;
  localparam int NB   = 3;
  localparam int W    = 16;
  localparam int TO_A = 5;
  localparam int IDA  = clog2_min1(NA);
  localparam int IDB  = clog2_min1(NB);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_PORTS(NA), .WIDTH(W), .ID_W(IDA)) ia ();
  fifo_wr_arbiter_if #(.N_PORTS(NB), .WIDTH(W), .ID_W(IDB)) ib ();

  fifo_wr_arbiter #(.N_PORTS(NA), .WIDTH(W), .TIMEOUT(TO_A), .CNT_W(8)) dut_a (
    .clk (clk), .rst (rst), .bus (ia)
  );
  fifo_wr_arbiter #(.N_PORTS(NB), .WIDTH(W), .TIMEOUT(255), .CNT_W(8)) dut_b (
    .clk (clk), .rst (rst), .bus (ib)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state: owner of the write port, next search start, idle-beat age
  bit m_busy;
  int m_g, m_ptr, m_sil, m_err_port;
  bit m_err_to;

  logic [W:0] pq [NA][$];   // per-port pending beats: {last, data}
  int  stall [NA];
  bit  acc [NA];
  bit  rnd_on = 1'b0;

  int wr_cyc[$], wr_port[$];
  logic [W-1:0] wr_dat[$];
  int fe_cyc[$], fe_port[$];
  int err_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int p, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) pq[p].push_back({(b == len - 1), base + W'(b)});
  endtask

  task automatic drive_a();
    for (int p = 0; p < NA; p++) begin
      ia.s_valid[p] = (pq[p].size() > 0) && (stall[p] == 0);
      ia.s_last[p]  = (pq[p].size() > 0) ? pq[p][0][W] : 1'b0;
      ia.s_data[p*W +: W] = (pq[p].size() > 0) ? pq[p][0][W-1:0] : '0;
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int p = 0; p < NA; p++) if (pq[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic model_a();
    logic [NA-1:0] exp_rdy;
    bit wr, fnd, lst;
    int p;
    if (rst) begin
      m_busy = 0; m_g = 0; m_ptr = 0; m_sil = 0; m_err_port = 0; m_err_to = 0;
      chk("rst_s_ready", ia.s_ready, 0);
      chk("rst_wr_en", ia.fifo_wr_en, 0);
      chk("rst_busy", ia.busy, 0);
      chk("rst_grant_id", ia.grant_id, 0);
      chk("rst_err_port", ia.err_port, 0);
      for (int q = 0; q < NA; q++) acc[q] = 1'b0;
      cyc++;
      return;
    end
    chk("busy", ia.busy, m_busy);
    chk("grant_id", ia.grant_id, m_g);
    chk("err_timeout", ia.err_timeout, m_err_to);
    chk("err_port", ia.err_port, m_err_port);
    exp_rdy = '0;
    if (m_busy && !ia.fifo_full) exp_rdy[m_g] = 1'b1;
    chk("s_ready", ia.s_ready, exp_rdy);
    wr  = m_busy && ia.s_valid[m_g] && !ia.fifo_full;
    lst = 1'b0;
    chk("fifo_wr_en", ia.fifo_wr_en, wr);
    if (wr) begin
      lst = pq[m_g][0][W];
      chk("fifo_data", ia.fifo_data, pq[m_g][0][W-1:0]);
      wr_cyc.push_back(cyc); wr_port.push_back(m_g); wr_dat.push_back(pq[m_g][0][W-1:0]);
      if (lst) begin fe_cyc.push_back(cyc); fe_port.push_back(m_g); end
    end
    if (ia.err_timeout) err_cyc.push_back(cyc);
    for (int q = 0; q < NA; q++) acc[q] = ia.s_valid[q] && ia.s_ready[q];
    m_err_to = 1'b0;
    if (!m_busy) begin
      fnd = 1'b0;
      for (int k = 0; k < NA; k++) begin
        p = (m_ptr + k) % NA;
        if (!fnd && ia.s_valid[p]) begin fnd = 1'b1; m_busy = 1; m_g = p; m_sil = 0; end
      end
    end else if (wr) begin
      m_sil = 0;
      if (lst) begin m_busy = 0; m_ptr = (m_g + 1) % NA; end
    end else if (!ia.s_valid[m_g]) begin
      if (m_sil + 1 == TO_A) begin
        m_busy = 0; m_ptr = (m_g + 1) % NA; m_err_port = m_g; m_err_to = 1; m_sil = 0;
      end else m_sil++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_a();
    @(posedge clk);
    #1;
    for (int p = 0; p < NA; p++) if (acc[p]) void'(pq[p].pop_front());
    if (rnd_on) begin
      ia.fifo_full = ($urandom_range(3) == 0);
      for (int p = 0; p < NA; p++) begin
        if (stall[p] > 0) stall[p]--;
        else if ($urandom_range(63) == 0) stall[p] = $urandom_range(8, 3);
        else if ($urandom_range(7) == 0) stall[p] = 1;
        if (pq[p].size() == 0 && $urandom_range(7) == 0)
          push_frame(p, $urandom_range(4, 1), W'($urandom));
      end
    end
    drive_a();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (all_empty() && !m_busy) break;
      tick();
    end
    chk(tag, {30'd0, all_empty(), m_busy}, 32'd2);
  endtask

  task automatic chk_b_id(input string tag);
    chk(tag, (ib.grant_id < 2'd3), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int c0, n0, f0, e0, cb;
    rst = 1'b1;
    ia.s_valid = '0; ia.s_last = '0; ia.s_data = '0; ia.fifo_full = 1'b0;
    ib.s_valid = '0; ib.s_last = '0; ib.s_data = '0; ib.fifo_full = 1'b0;
    for (int p = 0; p < NA; p++) stall[p] = 0;
    #1;
    chk("t0_busy", ia.busy, 0);
    chk("t0_err_timeout", ia.err_timeout, 0);
    chk("t0_b_busy", ib.busy, 0);
    tick(); tick();
    rst = 1'b0;

    // 1: single 3-beat frame on port 0
    push_frame(0, 3, 16'h00A0);
    drive_a();
    c0 = cyc; n0 = wr_cyc.size();
    drain("t1_drain", 20);
    chk("t1_nwrites", wr_cyc.size() - n0, 3);
    for (int b = 0; b < 3; b++) begin
      chk("t1_wr_cycle", wr_cyc[n0+b] - c0, b + 1);
      chk("t1_wr_data", wr_dat[n0+b], 16'h00A0 + 16'(b));
    end
    chk("t1_busy_after", ia.busy, 0);

    // 2: all ports saturated with 2-beat frames; pointer resumes at 1
    for (int p = 0; p < NA; p++) begin
      push_frame(p, 2, 16'(p * 256));
      push_frame(p, 2, 16'(p * 256 + 16));
    end
    drive_a();
    c0 = cyc; f0 = fe_cyc.size();
    drain("t2_drain", 60);
    chk("t2_nframes", fe_cyc.size() - f0, 8);
    chk("t2_first_end", fe_cyc[f0] - c0, 2);
    for (int k = 0; k < 5; k++) chk("t2_order", fe_port[f0+k], (1 + k) % NA);
    for (int k = 1; k < 8; k++) chk("t2_period", fe_cyc[f0+k] - fe_cyc[f0+k-1], 3);

    // 3: full held mid-frame never times out and holds the grant
    push_frame(2, 3, 16'h00C0);
    drive_a();
    n0 = wr_cyc.size(); e0 = err_cyc.size();
    tick(); tick();
    ia.fifo_full = 1'b1;
    repeat (10) tick();
    #1;
    chk("t3_grant_held", ia.grant_id, 2);
    chk("t3_busy_held", ia.busy, 1);
    chk("t3_no_writes", wr_cyc.size() - n0, 1);
    ia.fifo_full = 1'b0;
    drain("t3_drain", 20);
    chk("t3_nwrites", wr_cyc.size() - n0, 3);
    chk("t3_end_port", fe_port[$], 2);
    chk("t3_no_timeout", err_cyc.size() - e0, 0);

    // 4: port 1 goes silent mid-frame; port 3 waits
    pq[1].push_back({1'b0, 16'h00D0});
    drive_a();
    n0 = wr_cyc.size(); e0 = err_cyc.size();
    tick();
    cb = cyc;
    tick();
    push_frame(3, 2, 16'h00E0);
    drive_a();
    repeat (10) tick();
    chk("t4_d0_cycle", wr_cyc[n0] - cb, 0);
    chk("t4_nerr", err_cyc.size() - e0, 1);
    chk("t4_err_cycle", err_cyc[$] - cb, 6);
    chk("t4_err_port", ia.err_port, 1);
    chk("t4_next_port", wr_port[n0+1], 3);
    chk("t4_next_cycle", wr_cyc[n0+1] - cb, 7);
    chk("t4_next_data", wr_dat[n0+1], 16'h00E0);
    drain("t4_drain", 20);

    // 5: async reset mid-frame with a nonzero pointer
    push_frame(1, 1, 16'h0011);
    drive_a();
    drain("t5_pre_drain", 20);
    push_frame(2, 4, 16'h0020);
    drive_a();
    tick(); tick();
    #1;
    chk("t5_pre_ready", ia.s_ready, 4'b0100);
    chk("t5_pre_wr_en", ia.fifo_wr_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_ready", ia.s_ready, 0);
    chk("t5_async_wr_en", ia.fifo_wr_en, 0);
    chk("t5_async_busy", ia.busy, 0);
    for (int p = 0; p < NA; p++) pq[p].delete();
    drive_a();
    tick(); tick();
    rst = 1'b0;
    push_frame(2, 1, 16'h0022);
    push_frame(0, 1, 16'h0033);
    drive_a();
    tick();
    #1;
    chk("t5_first_grant", ia.grant_id, 0);
    chk("t5_first_busy", ia.busy, 1);
    drain("t5_drain", 20);

    // 6: three-port pointer wrap on dut_b
    ib.s_last = 3'b111;
    ib.s_data[2*W +: W] = 16'h00B2;
    ib.s_data[0 +: W]   = 16'h00B0;
    ib.s_valid = 3'b100;
    #1;
    chk("t6_arb_wr_en", ib.fifo_wr_en, 0);
    tick(); #1;
    chk("t6_grant2", ib.grant_id, 2);
    chk("t6_ready2", ib.s_ready, 3'b100);
    chk("t6_data2", ib.fifo_data, 16'h00B2);
    chk_b_id("t6_id_a");
    tick();
    ib.s_valid = 3'b101;
    #1;
    chk("t6_idle_busy", ib.busy, 0);
    chk("t6_idle_wr_en", ib.fifo_wr_en, 0);
    tick(); #1;
    chk("t6_wrap_grant", ib.grant_id, 0);
    chk("t6_wrap_ready", ib.s_ready, 3'b001);
    chk("t6_wrap_data", ib.fifo_data, 16'h00B0);
    chk_b_id("t6_id_b");
    tick();
    ib.s_valid = 3'b100;
    tick(); #1;
    chk("t6_after_grant", ib.grant_id, 2);
    chk_b_id("t6_id_c");
    tick();
    ib.s_valid = 3'b000;
    tick(); #1;
    chk("t6_done_busy", ib.busy, 0);
    chk_b_id("t6_id_d");

    // randomized traffic, stalls, full, and occasional watchdog releases
    rnd_on = 1'b1;
    repeat (3000) tick();
    rnd_on = 1'b0;
    ia.fifo_full = 1'b0;
    for (int p = 0; p < NA; p++) stall[p] = 0;
    drive_a();
    drain("rnd_drain", 600);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
